// File: rtl/fpu_types.sv
// Shared FPU types: writeback producer indices and the round-robin helper
// used by the FP writeback arbiter and other FPU arbiters.
package fpu_types;

   localparam int FP_WB_NUM_UNITS = 4;

   localparam int FP_WB_FMADD   = 0;
   localparam int FP_WB_FMUL    = 1;
   localparam int FP_WB_DIVSQRT = 2;
   localparam int FP_WB_WB2FP   = 3;

   typedef logic [$clog2(FP_WB_NUM_UNITS)-1:0] fp_wb_src_t;

   // Pointer advance past the winner, wrapping at the last unit.
   function automatic int rr_next(input int idx, input int num_units);
      return (idx + 1 == num_units) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Writeback bus between the FP execution producers, the arbiter and the
// normalization/rounding pipeline. slave is the arbiter side.
interface fp_wb_arbiter_if
   import fpu_types::*;
#(
   parameter int NUM_WB_UNITS = FP_WB_NUM_UNITS,
   parameter int DATA_W       = 128,
   parameter int ID_W         = 2
);
   localparam int SRC_W = $clog2(NUM_WB_UNITS);

   logic [NUM_WB_UNITS-1:0]        req_done;
   logic [NUM_WB_UNITS*ID_W-1:0]   req_id;
   logic [NUM_WB_UNITS*DATA_W-1:0] req_data;
   logic [NUM_WB_UNITS-1:0]        req_ack;
   logic                           out_valid;
   logic                           out_ready;
   logic [ID_W-1:0]                out_id;
   logic [DATA_W-1:0]              out_data;
   logic [SRC_W-1:0]               out_src;

   modport master (
      output req_done, req_id, req_data, out_ready,
      input  req_ack, out_valid, out_id, out_data, out_src
   );

   modport slave (
      input  req_done, req_id, req_data, out_ready,
      output req_ack, out_valid, out_id, out_data, out_src
   );

endinterface

// File: rtl/fp_wb_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, found
// by a priority encode over the request vector concatenated with itself.
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic [2*NUM_REQ-1:0] dbl;
   logic                 found;

   assign dbl = {req, req};

   // Bits below ptr in the lower copy are masked; the upper copy supplies the wrap.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int j = 0; j < 2 * NUM_REQ; j++) begin
         if (!found && dbl[j] && j >= int'(ptr)) begin
            found      = 1'b1;
            idx        = IDX_W'(j % NUM_REQ);
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Round-robin writeback arbiter feeding the shared FP normalization/rounding
// pipeline through a single registered output stage.
module fp_wb_arbiter
   import fpu_types::*;
#(
   parameter int NUM_WB_UNITS = FP_WB_NUM_UNITS,
   parameter int DATA_W       = 128,
   parameter int ID_W         = 2
) (
   input  logic           clk,
   input  logic           rst,
   fp_wb_arbiter_if.slave bus
);

   localparam int SRC_W = $clog2(NUM_WB_UNITS);

   logic [SRC_W-1:0]        rr_ptr;
   logic [SRC_W-1:0]        win_idx;
   logic [NUM_WB_UNITS-1:0] win_onehot;
   logic                    load;
   logic                    grant;
   logic [DATA_W-1:0]       sel_data;
   logic [ID_W-1:0]         sel_id;

   logic                    out_valid_q;
   logic [ID_W-1:0]         out_id_q;
   logic [DATA_W-1:0]       out_data_q;
   logic [SRC_W-1:0]        out_src_q;

   rr_priority_picker #(
      .NUM_REQ (NUM_WB_UNITS),
      .IDX_W   (SRC_W)
   ) picker (
      .req   (bus.req_done),
      .ptr   (rr_ptr),
      .grant (win_onehot),
      .idx   (win_idx)
   );

   // The output slot can take a new result when empty or being drained now.
   assign load  = ~out_valid_q | bus.out_ready;
   assign grant = load & (|bus.req_done) & ~rst;

   assign bus.req_ack = grant ? win_onehot : '0;

   always_comb begin
      sel_data = '0;
      sel_id   = '0;
      for (int i = 0; i < NUM_WB_UNITS; i++) begin
         if (win_onehot[i]) begin
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
            sel_id   = bus.req_id[i*ID_W +: ID_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (load) begin
         out_valid_q <= grant;
         if (grant) begin
            out_data_q <= sel_data;
            out_id_q   <= sel_id;
            out_src_q  <= win_idx;
            rr_ptr     <= SRC_W'(rr_next(int'(win_idx), NUM_WB_UNITS));
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_id    = out_id_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: behavioural round-robin model plus a scoreboard of
// granted results that must appear on the output stage in grant order.
module tb_fp_wb_arbiter;
   import fpu_types::*;

   localparam int N  = 4;
   localparam int DW = 128;
   localparam int IW = 2;
   localparam int SW = 2;

   typedef struct packed {
      logic [SW-1:0] src;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } entry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_wb_arbiter_if #(.NUM_WB_UNITS(N), .DATA_W(DW), .ID_W(IW)) bus ();

   fp_wb_arbiter #(.NUM_WB_UNITS(N), .DATA_W(DW), .ID_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   entry_t        sb[$];
   logic [N-1:0]  pend;
   logic [IW-1:0] pid[N];
   logic [DW-1:0] pdat[N];
   int            waitc[N];
   int            mptr;
   logic          mvalid;
   logic          rdy;
   logic [N-1:0]  obs_ack;
   int            serial;
   int            checks;
   int            failures;

   task automatic check_output(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic new_result(input int i);
      pend[i]  = 1'b1;
      pid[i]   = IW'($urandom);
      pdat[i]  = {32'(serial), 32'($urandom), 32'($urandom), 32'($urandom)};
      waitc[i] = 0;
      serial++;
   endtask

   task automatic apply_stimulus();
      bus.req_done  = pend;
      bus.out_ready = rdy;
      for (int i = 0; i < N; i++) begin
         bus.req_id[i*IW +: IW]   = pid[i];
         bus.req_data[i*DW +: DW] = pdat[i];
      end
   endtask

   // One clock: check the combinational ack, advance the model, check the output stage.
   task automatic step();
      logic [N-1:0] eack;
      logic         load;
      int           w;
      apply_stimulus();
      #1;
      eack = '0;
      w    = -1;
      load = !mvalid || rdy;
      if (!rst && load) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
         end
      end
      if (w >= 0) eack[w] = 1'b1;
      obs_ack = bus.req_ack;
      check_output("ack", obs_ack, eack);
      if (rst) begin
         sb.delete();
         for (int i = 0; i < N; i++) waitc[i] = 0;
         mvalid = 1'b0;
         mptr   = 0;
      end else begin
         if (mvalid && rdy && sb.size() > 0) void'(sb.pop_front());
         if (w >= 0) begin
            check_output("fair", DW'(waitc[w] <= N - 1), DW'(1));
            for (int i = 0; i < N; i++) begin
               if (i != w && pend[i]) waitc[i]++;
            end
            sb.push_back('{src: SW'(w), id: pid[w], data: pdat[w]});
         end
         if (load) begin
            mvalid = (w >= 0);
            if (w >= 0) mptr = (w + 1) % N;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_output("out_valid", DW'(bus.out_valid), DW'(mvalid));
      if (mvalid && sb.size() > 0) begin
         check_output("out_src", DW'(bus.out_src), DW'(sb[0].src));
         check_output("out_id", DW'(bus.out_id), DW'(sb[0].id));
         check_output("out_data", bus.out_data, sb[0].data);
      end
      if (w >= 0) pend[w] = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      serial   = 1;
      mptr     = 0;
      mvalid   = 1'b0;
      rdy      = 1'b1;
      pend     = '0;
      for (int i = 0; i < N; i++) begin
         pid[i]   = '0;
         pdat[i]  = '0;
         waitc[i] = 0;
      end
      apply_stimulus();
      @(negedge clk);

      // Reset with all producers requesting: no ack, output stage cleared.
      for (int i = 0; i < N; i++) new_result(i);
      rst = 1'b1;
      step();
      step();
      check_output("rst_valid", DW'(bus.out_valid), '0);
      check_output("rst_src", DW'(bus.out_src), '0);
      check_output("rst_id", DW'(bus.out_id), '0);
      check_output("rst_data", bus.out_data, '0);
      rst = 1'b0;

      // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 8; i++) begin
         step();
         check_output("rot_ack", DW'(obs_ack), DW'(4'b0001 << (i % 4)));
         if (i < 4) new_result(i % 4);
      end

      // Producer 2 alone, three back-to-back results.
      for (int i = 0; i < 3; i++) begin
         new_result(FP_WB_DIVSQRT);
         step();
         check_output("p2_ack", DW'(obs_ack), DW'(4'b0100));
         check_output("p2_valid", DW'(bus.out_valid), DW'(1));
      end

      // rr_ptr=3, only producer 0: granted through the wrap.
      new_result(FP_WB_FMADD);
      step();
      check_output("wrap_ack", DW'(obs_ack), DW'(4'b0001));

      // rr_ptr=1 now, producer 1 wins, then stall with 0 and 3 waiting.
      new_result(FP_WB_FMUL);
      step();
      check_output("p1_ack", DW'(obs_ack), DW'(4'b0010));
      new_result(FP_WB_FMADD);
      new_result(FP_WB_WB2FP);
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_output("stall_ack", DW'(obs_ack), '0);
         check_output("stall_src", DW'(bus.out_src), DW'(1));
      end
      rdy = 1'b1;
      step();
      check_output("resume_ack", DW'(obs_ack), DW'(4'b1000));
      step();
      check_output("next_ack", DW'(obs_ack), DW'(4'b0001));

      // Reset while holding a result with producer 1 pending.
      new_result(FP_WB_FMUL);
      rdy = 1'b0;
      rst = 1'b1;
      step();
      check_output("midrst_ack", DW'(obs_ack), '0);
      check_output("midrst_valid", DW'(bus.out_valid), '0);
      rst = 1'b0;
      rdy = 1'b1;
      new_result(FP_WB_DIVSQRT);
      step();
      check_output("postrst_ack", DW'(obs_ack), DW'(4'b0010));
      step();
      check_output("postrst_ack2", DW'(obs_ack), DW'(4'b0100));

      // Random done/ready traffic.
      for (int c = 0; c < 400; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) new_result(i);
         end
         step();
      end

      // Drain: every pending result gets acked and leaves the output stage.
      rdy = 1'b1;
      for (int c = 0; c < 10; c++) step();
      check_output("drain_pend", DW'(pend), '0);
      check_output("drain_sb", DW'(sb.size()), '0);
      check_output("drain_valid", DW'(bus.out_valid), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
